// File: rtl/result_mem_arbiter.sv
// Single-port scheduler for the grayscale result memory. Shares one memory
// port between the display prefetch FIFO and the processor load/store port.
// Display refill wins when the FIFO is nearly empty, otherwise the CPU wins.
module result_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int NUM_PIX    = 307200,
  parameter int FIFO_DEPTH = 4,
  parameter int URGENT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Who owns the data coming back on mem_rdata this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  owner_t            owner_q;
  owner_t            owner_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_pix;
  logic              underflow_q;

  logic              restart;
  logic              inflight;
  int                occupancy;
  logic              disp_eligible;
  logic              disp_urgent;
  logic              issue_disp;
  logic              push;
  logic              pop_ok;

  // A restart (reset or new frame) blocks issue and discards display returns.
  assign restart  = rst | frame_start;
  assign inflight = (owner_q == OWN_DISP);

  // Display eligibility counts entries already stored plus the one returning.
  always_comb begin
    occupancy     = int'(count) + int'(inflight);
    disp_eligible = !fetch_done && (occupancy < FIFO_DEPTH);
    disp_urgent   = disp_eligible && (occupancy < URGENT);
  end

  // Per-cycle arbitration: urgent display, then CPU, then opportunistic display.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    issue_disp = 1'b0;
    cpu_gnt    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = last_addr;
    mem_wdata  = '0;
    owner_d    = OWN_NONE;
    if (restart) begin
      issue_disp = 1'b0;
    end else if (disp_urgent) begin
      issue_disp = 1'b1;
      mem_addr   = fetch_addr;
      owner_d    = OWN_DISP;
    end else if (cpu_req) begin
      cpu_gnt  = 1'b1;
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      if (cpu_we) begin
        mem_wdata = cpu_wdata;
      end else begin
        owner_d = OWN_CPU;
      end
    end else if (disp_eligible) begin
      issue_disp = 1'b1;
      mem_addr   = fetch_addr;
      owner_d    = OWN_DISP;
    end
  end

  // FIFO push/pop qualification; a restart cycle ignores both.
  assign push   = (owner_q == OWN_DISP) && !restart;
  assign pop_ok = pix_pop && (count != '0) && !restart;

  // FIFO storage; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; pointers and count alone define
    // which entries are meaningful, so clearing the storage is unnecessary.
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rdata;
    end
  end

  // Control state: pointers, count, fetch address, sticky underflow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (restart) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_addr  <= '0;
      fetch_done  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pix_pop && (count == '0)) begin
        underflow_q <= 1'b1;
      end
      if (issue_disp) begin
        fetch_addr <= fetch_addr + 1'b1;
        if (fetch_addr == ADDR_W'(NUM_PIX - 1)) begin
          fetch_done <= 1'b1;
        end
      end
    end
  end

  // Return ownership, held address for idle cycles, last popped pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= OWN_NONE;
      last_addr <= '0;
      last_pix  <= '0;
    end else begin
      owner_q <= owner_d;
      if (issue_disp || cpu_gnt) begin
        last_addr <= mem_addr;
      end
      if (pop_ok) begin
        last_pix <= fifo_mem[rd_ptr];
      end
    end
  end

  assign pix_valid  = (count != '0);
  assign pix_data   = pix_valid ? fifo_mem[rd_ptr] : last_pix;
  assign underflow  = underflow_q;
  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

endmodule
